// File: rtl/sa_pkg.sv
// ============================================================================
// Module  : sa_pkg
// Brief   : Shared constants for the serial word assembler: FSM state
//           encodings and the default assembled word width.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sa_pkg;

    localparam int c_default_width = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sa_shift_reg.sv
// ============================================================================
// Module  : sa_shift_reg
// Brief   : WIDTH-bit capture register with indexed single-bit write and a
//           synchronous clear that may coincide with a write.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sa_shift_reg
    import sa_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Clear and write in the same cycle: bit 0 of a new word lands on a clean register.
    always_comb begin
        w_next = i_clr ? '0 : r_q;
        if (i_en) begin
            w_next[i_idx] = i_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en || i_clr) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_assembler.sv
// ============================================================================
// Module  : serial_word_assembler
// Brief   : Deserializes an LSB-first qualified bit stream into WIDTH-bit
//           words with a one-cycle Load pulse. Optional even-parity frame
//           check enabled by defining PARITY_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_assembler
    import sa_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SerIn,
    input  logic             SerValid,
    input  logic             Abort,
    output logic [WIDTH-1:0] Word,
    output logic             Load,
    output logic             Busy,
    output logic             ParErr
);

    localparam int IDX_W = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_word;
    logic             r_load;
    logic [WIDTH-1:0] w_shreg;
    logic             w_take;
    logic             w_sh_en;
    logic             w_sh_clr;
    logic [IDX_W-1:0] w_sh_idx;
    logic             w_last_bit;

    assign w_take     = SerValid && !Abort;
    assign w_sh_en    = w_take && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));
    assign w_sh_clr   = w_take && (r_state == ST_IDLE);
    assign w_sh_idx   = (r_state == ST_IDLE) ? '0 : r_count[IDX_W-1:0];
    assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

    sa_shift_reg #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_shreg (
        .clk   (CLK),
        .rst   (RST),
        .i_en  (w_sh_en),
        .i_clr (w_sh_clr),
        .i_idx (w_sh_idx),
        .i_bit (SerIn),
        .o_q   (w_shreg)
    );

`ifdef PARITY_CHECK_EN
    logic r_par;
    logic r_par_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_par     <= 1'b0;
            r_word    <= '0;
            r_load    <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_load    <= 1'b0;
            r_par_err <= 1'b0;
            if (Abort) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_par   <= 1'b0;
            end else if (SerValid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SHIFT;
                        r_count <= CNT_W'(1);
                        r_par   <= SerIn;
                    end
                    ST_SHIFT: begin
                        r_count <= r_count + CNT_W'(1);
                        r_par   <= r_par ^ SerIn;
                        if (w_last_bit) begin
                            r_state <= ST_PAR;
                        end
                    end
                    ST_PAR: begin
                        // Even parity across data plus parity bit must XOR to zero.
                        if ((r_par ^ SerIn) == 1'b0) begin
                            r_word <= w_shreg;
                            r_load <= 1'b1;
                        end else begin
                            r_par_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_par   <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_par   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ParErr = r_par_err;
`else
    logic [WIDTH-1:0] w_assembled;

    // The completing bit is still on SerIn; merge it so Word updates on its sampling edge.
    always_comb begin
        w_assembled            = w_shreg;
        w_assembled[WIDTH-1]   = SerIn;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_word  <= '0;
            r_load  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (Abort) begin
                r_state <= ST_IDLE;
                r_count <= '0;
            end else if (SerValid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SHIFT;
                        r_count <= CNT_W'(1);
                    end
                    ST_SHIFT: begin
                        if (w_last_bit) begin
                            r_word  <= w_assembled;
                            r_load  <= 1'b1;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign ParErr = 1'b0;
`endif

    assign Word = r_word;
    assign Load = r_load;
    assign Busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
// ============================================================================
// Module  : tb_serial_word_assembler
// Brief   : Directed self-checking bench for serial_word_assembler
//           (parity scenario included when PARITY_CHECK_EN is defined).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_word_assembler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SerIn;
    logic       SerValid;
    logic       Abort;
    logic [3:0] Word;
    logic       Load;
    logic       Busy;
    logic       ParErr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    serial_word_assembler #(.WIDTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SerIn    (SerIn),
        .SerValid (SerValid),
        .Abort    (Abort),
        .Word     (Word),
        .Load     (Load),
        .Busy     (Busy),
        .ParErr   (ParErr)
    );

    // Inputs change on the falling edge; outputs seen then reflect the previous rising edge.
    task automatic step(input logic v, input logic b, input logic a);
        @(negedge CLK);
        SerValid = v;
        SerIn    = b;
        Abort    = a;
    endtask

    task automatic send_word(input logic [3:0] d);
        for (int i = 0; i < 4; i++) step(1'b1, d[i], 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, ^d, 1'b0);
`endif
    endtask

    task automatic test_reset();
        RST = 1'b1; SerValid = 1'b0; SerIn = 1'b0; Abort = 1'b0;
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({Word, Load, Busy, ParErr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got W=%h L=%b B=%b P=%b, want all 0", Word, Load, Busy, ParErr);
        end
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({Word, Load, Busy, ParErr} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got W=%h L=%b B=%b P=%b, want all 0", i, Word, Load, Busy, ParErr);
            end
        end
    endtask

    task automatic test_single_word();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (Busy !== 1'b1 || Load !== 1'b0) begin
            n_fail++;
            $display("FAIL single_midword: got B=%b L=%b, want B=1 L=0", Busy, Load);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b1, 1'b0);
`endif
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b1 || Word !== 4'hD || Busy !== 1'b0 || ParErr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_load: got L=%b W=%h B=%b P=%b, want L=1 W=d B=0 P=0", Load, Word, Busy, ParErr);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b0 || Word !== 4'hD) begin
            n_fail++;
            $display("FAIL single_pulse_end: got L=%b W=%h, want L=0 W=d", Load, Word);
        end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Busy !== 1'b0 || Load !== 1'b0 || Word !== 4'hD || ParErr !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_midword: got B=%b L=%b W=%h P=%b, want B=0 L=0 W=d P=0", Busy, Load, Word, ParErr);
        end
        send_word(4'hF);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b1 || Word !== 4'hF) begin
            n_fail++;
            $display("FAIL abort_next_word: got L=%b W=%h, want L=1 W=f", Load, Word);
        end
        // Abort lands on the cycle that would have completed the word.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b0, 1'b0);
`endif
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b0 || Busy !== 1'b0 || Word !== 4'hF || ParErr !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_last_bit: got L=%b B=%b W=%h P=%b, want L=0 B=0 W=f P=0", Load, Busy, Word, ParErr);
        end
    endtask

    task automatic test_back_to_back();
        send_word(4'h1);
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b1 || Word !== 4'h1) begin
            n_fail++;
            $display("FAIL b2b_first: got L=%b W=%h, want L=1 W=1", Load, Word);
        end
        step(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (Load !== 1'b0 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_between: got L=%b B=%b, want L=0 B=1", Load, Busy);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b1, 1'b0);
`endif
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b1 || Word !== 4'h2) begin
            n_fail++;
            $display("FAIL b2b_second: got L=%b W=%h, want L=1 W=2", Load, Word);
        end
    endtask

    task automatic test_gap_reset();
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Busy !== 1'b1 || Load !== 1'b0 || Word !== 4'h2) begin
            n_fail++;
            $display("FAIL gap_hold: got B=%b L=%b W=%h, want B=1 L=0 W=2", Busy, Load, Word);
        end
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if (Word !== 4'h0 || Busy !== 1'b0 || Load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got W=%h B=%b L=%b, want W=0 B=0 L=0", Word, Busy, Load);
        end
        @(negedge CLK);
        RST = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b0 || Word !== 4'h0 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_restart: got L=%b W=%h B=%b, want L=0 W=0 B=1", Load, Word, Busy);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Busy !== 1'b0 || Load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cleanup: got B=%b L=%b, want B=0 L=0", Busy, Load);
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        send_word(4'hD);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (Load !== 1'b1 || Word !== 4'hD || ParErr !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: got L=%b W=%h P=%b, want L=1 W=d P=0", Load, Word, ParErr);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (ParErr !== 1'b1 || Load !== 1'b0 || Word !== 4'hD) begin
            n_fail++;
            $display("FAIL parity_bad: got P=%b L=%b W=%h, want P=1 L=0 W=d", ParErr, Load, Word);
        end
        step(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (ParErr !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_pulse_end: got P=%b B=%b, want P=0 B=0", ParErr, Busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_abort();
        test_back_to_back();
        test_gap_reset();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
